// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use bubbles, branch squashes, dmem wait freeze + timeout.
// Optional STALL_PERF_CNT_EN adds saturating perf counters perf_lu/perf_br/perf_mw.
module pipeline_stall_ctrl #(
  parameter int ASIZE       = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int WAIT_CW     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idex_memread,
  input  logic [ASIZE-1:0] idex_rt,
  input  logic [ASIZE-1:0] ifid_rs,
  input  logic [ASIZE-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_bubble,
`ifdef STALL_PERF_CNT_EN
  output logic [15:0]      perf_lu,
  output logic [15:0]      perf_br,
  output logic [15:0]      perf_mw,
`endif
  output logic             stall_err
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

  state_t             state_q, state_d;
  logic [WAIT_CW-1:0] wait_cnt_q, wait_cnt_d;
  logic               load_use;
  logic               freeze;
  logic               lu_evt;
  logic               br_evt;

  assign load_use = idex_memread && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    freeze       = 1'b0;
    lu_evt       = 1'b0;
    br_evt       = 1'b0;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    case (state_q)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_CW'(1);
        end else if (branch_taken) begin
          br_evt     = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          lu_evt     = 1'b1;
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
      // EX is held here, so branch and load-use inputs are stale and ignored
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt_q == WAIT_CW'(MEM_TIMEOUT)) state_d = ERR;
          else wait_cnt_d = wait_cnt_q + WAIT_CW'(1);
        end
      end
      ERR:     freeze  = 1'b1;
      default: state_d = RUN;
    endcase
    if (freeze) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end
    if (!rst_n) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      ifid_flush   = 1'b0;
      idex_en      = 1'b0;
      idex_flush   = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      stall_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      stall_err  <= stall_err | (state_d == ERR);
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic mw_evt;
  assign mw_evt = freeze && (state_q != ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu <= '0;
      perf_br <= '0;
      perf_mw <= '0;
    end else begin
      if (lu_evt && perf_lu != 16'hFFFF) perf_lu <= perf_lu + 16'd1;
      if (br_evt && perf_br != 16'hFFFF) perf_br <= perf_br + 16'd1;
      if (mw_evt && perf_mw != 16'hFFFF) perf_mw <= perf_mw + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed hazard scenarios followed by random traffic vs a reference model.
module tb_pipeline_stall_ctrl;
  localparam int MEM_TIMEOUT = 15;

  localparam logic [6:0] V_OFF    = 7'b0000000;
  localparam logic [6:0] V_RUN    = 7'b1101010;
  localparam logic [6:0] V_FROZEN = 7'b0000001;
  localparam logic [6:0] V_BR     = 7'b1111110;
  localparam logic [6:0] V_LU     = 7'b0001110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       idex_memread = 1'b0;
  logic [4:0] idex_rt = '0, ifid_rs = '0, ifid_rt = '0;
  logic       ifid_uses_rt = 1'b0, branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, stall_err;
`ifdef STALL_PERF_CNT_EN
  logic [15:0] perf_lu, perf_br, perf_mw;
`endif

  int vectors = 0;
  int miscompares = 0;

  // reference model state: frozen cycles in the current memory wait, error flag, event tallies
  int frozen = 0;
  bit m_err = 0;
  int m_lu = 0, m_br = 0, m_mw = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.ASIZE(5), .MEM_TIMEOUT(MEM_TIMEOUT), .WAIT_CW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .idex_memread(idex_memread), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_bubble(memwb_bubble),
`ifdef STALL_PERF_CNT_EN
    .perf_lu(perf_lu), .perf_br(perf_br), .perf_mw(perf_mw),
`endif
    .stall_err(stall_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic step(input bit r, input bit mr, input logic [4:0] rt, input logic [4:0] rs,
                      input logic [4:0] rt2, input bit ur, input bit br, input bit rq,
                      input bit rd, input string tag);
    logic [6:0] exp;
    bit lu;
    @(negedge clk);
    rst_n = r; idex_memread = mr; idex_rt = rt; ifid_rs = rs; ifid_rt = rt2;
    ifid_uses_rt = ur; branch_taken = br; dmem_req = rq; dmem_ready = rd;
    #1;
    if (!r) begin
      frozen = 0; m_err = 0; m_lu = 0; m_br = 0; m_mw = 0;
    end
    chk({tag, ".err"}, 16'(stall_err), 16'(m_err));
`ifdef STALL_PERF_CNT_EN
    chk({tag, ".perf_lu"}, perf_lu, 16'(m_lu));
    chk({tag, ".perf_br"}, perf_br, 16'(m_br));
    chk({tag, ".perf_mw"}, perf_mw, 16'(m_mw));
`endif
    lu = mr && rt != 0 && (rt == rs || (ur && rt == rt2));
    if (!r) exp = V_OFF;
    else if (m_err) exp = V_FROZEN;
    else if (frozen > 0 || (rq && !rd)) begin
      if (rd) begin
        exp = V_RUN;
        frozen = 0;
      end else begin
        exp = V_FROZEN;
        frozen++;
        m_mw = sat_inc(m_mw);
        // the freeze may last MEM_TIMEOUT+1 cycles; running out of budget is an error
        if (frozen == MEM_TIMEOUT + 1) m_err = 1;
      end
    end
    else if (br) begin exp = V_BR; m_br = sat_inc(m_br); end
    else if (lu) begin exp = V_LU; m_lu = sat_inc(m_lu); end
    else exp = V_RUN;
    chk({tag, ".ctl"}, 16'({pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble}),
        16'(exp));
  endtask

  task automatic idle(input string tag);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "rst0");
    step(0, 1, 8, 8, 0, 0, 1, 1, 0, "rst_busy");
    idle("rel");
    step(1, 1, 8, 8, 0, 0, 0, 0, 0, "lu_rs");
    idle("lu_after");
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, "lu_r0");
    step(1, 1, 9, 3, 9, 1, 0, 0, 0, "lu_rt");
    step(1, 1, 9, 3, 9, 0, 0, 0, 0, "lu_rt_unused");
    step(1, 1, 8, 8, 0, 0, 1, 0, 0, "br_lu");
    idle("br_after");
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, "mem_fast");
    for (int i = 0; i < 3; i++) step(1, 1, 8, 8, 0, 0, 1, 1, 0, "mw_hold");
    step(1, 0, 0, 0, 0, 0, 1, 1, 1, "mw_ready");
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, "mw_br_next");
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 0, "to_hold");
    chk("to_sticky", 16'(stall_err), 16'd1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, "err_ready");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, "err_rst");
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 0, "wait_rst_hold");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, "wait_rst");
    idle("wait_rst_rel");
`ifdef STALL_PERF_CNT_EN
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "perf_rst");
    for (int i = 0; i < 2; i++) step(1, 1, 4, 4, 0, 0, 0, 0, 0, "perf_lu");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 1, 0, 0, "perf_br");
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 0, "perf_mw");
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, "perf_done");
    idle("perf_idle");
    chk("perf_lu_tot", perf_lu, 16'd2);
    chk("perf_br_tot", perf_br, 16'd3);
    chk("perf_mw_tot", perf_mw, 16'd4);
`endif
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) != 0, 1'($urandom), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
           $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 2) != 0, "rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central hazard and stall sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives per-stage register enables and flushes for the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers.
- Resolves three hazard classes: load-use data hazards, taken-branch/jump squashes, and multi-cycle data-memory waits.
- Contains a small FSM with a memory-wait timeout and a sticky error flag.

Parameters:
ASIZE, 5, register-file address width; must match `ASIZE.
MEM_TIMEOUT, 15, max consecutive MEM_WAIT cycles before the error state (1..255).
WAIT_CW, 8, width of the wait counter; must satisfy 2^WAIT_CW > MEM_TIMEOUT.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
idex_memread  input  1  instruction in EX is a load.
idex_rt  input  ASIZE  load destination register in EX.
ifid_rs  input  ASIZE  rs of the instruction in ID.
ifid_rt  input  ASIZE  rt of the instruction in ID.
ifid_uses_rt  input  1  instruction in ID reads rt as a source.
branch_taken  input  1  EX resolved a taken branch, jr or jal redirect.
dmem_req  input  1  MEM stage is issuing a load or store this cycle.
dmem_ready  input  1  data memory completes the access this cycle.
pc_en  output  1  PC update enable.
ifid_en  output  1  IF_ID register load enable.
ifid_flush  output  1  IF_ID synchronous clear to NOP.
idex_en  output  1  ID_EX register load enable.
idex_flush  output  1  ID_EX clear to bubble (wen=0, memwrite=0, jal=0).
exmem_en  output  1  EX_MEM register load enable.
memwb_bubble  output  1  MEM_WB captures wen=0 and jal=0.
stall_err  output  1  sticky memory-timeout error.

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. State, wait counter and stall_err are registered.
- All other outputs are combinational decodes of the current state and inputs, so a stall takes effect in the same cycle as the hazard.
- Reset: rst_n low clears asynchronously. State=RUN, wait counter=0, stall_err=0.
- While rst_n is low, all enables=0, all flushes=0 and memwb_bubble=0.
- Default in RUN with no hazard: all enables=1, flushes=0, memwb_bubble=0.
- load_use = idex_memread && idex_rt!=0 && (idex_rt==ifid_rs || (ifid_uses_rt && idex_rt==ifid_rt)).
- RUN priority, highest first:
  - (1) dmem_req && !dmem_ready: pc_en=ifid_en=idex_en=exmem_en=0, memwb_bubble=1. Next state MEM_WAIT, counter<=1.
  - (2) branch_taken: ifid_flush=1, idex_flush=1, enables=1. Stay in RUN. This squashes exactly 2 younger instructions.
  - (3) load_use: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1. Inserts exactly 1 bubble. The hazard clears on the next cycle naturally.
- If dmem_req && dmem_ready in the same RUN cycle, treat as no memory stall.
- If branch_taken and load_use are both active, branch wins and no extra bubble is inserted.
- MEM_WAIT:
  - Pipeline is frozen as in RUN case (1), and branch_taken/load_use are ignored because EX is held.
  - dmem_ready=1: all enables=1, memwb_bubble=0 (the access completes and advances). Next state RUN, counter<=0. A held branch_taken is acted on in the next RUN cycle.
  - Else if counter==MEM_TIMEOUT: next state ERR.
  - Else counter<=counter+1.
  - Freeze length is therefore at most MEM_TIMEOUT+1 cycles.
- ERR: all enables=0, memwb_bubble=1, stall_err=1. Exit only via reset.
- Reset asserted mid-MEM_WAIT or in ERR: immediately returns to RUN, counter=0, stall_err=0.

Optional Feature:
STALL_PERF_CNT_EN
- Defined: adds outputs perf_lu[15:0], perf_br[15:0] and perf_mw[15:0].
  - perf_lu counts load-use bubble cycles.
  - perf_br counts branch flush cycles.
  - perf_mw counts RUN-case-(1) and MEM_WAIT freeze cycles.
  - Each counter saturates at 0xFFFF and clears on reset.
- Undefined: these ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset release with no hazards -> cycle 1: pc_en=ifid_en=idex_en=exmem_en=1, flushes=0, stall_err=0.
- idex_memread=1, idex_rt=8, ifid_rs=8 for one cycle -> that cycle: pc_en=0, ifid_en=0, idex_flush=1. Next cycle (memread=0) back to default. With idex_rt=0 instead -> no stall.
- branch_taken=1 together with load_use=1 -> ifid_flush=1, idex_flush=1, pc_en=1. No bubble on the following cycle.
- dmem_req=1, dmem_ready=0 for 3 cycles, then ready=1 -> 3 frozen cycles with memwb_bubble=1. Enables=1 on the ready cycle, then RUN.
- dmem_req=1, dmem_ready=0 held for 20 cycles with MEM_TIMEOUT=15 -> ERR entered after 16 frozen cycles, stall_err=1 sticky. Asserting rst_n=0 mid-hold clears it immediately.
- With STALL_PERF_CNT_EN: 2 load-use, 3 branch and 4 wait cycles -> perf_lu=2, perf_br=3, perf_mw=4.
